// File: rtl/if_resp_buffer_pkg.sv
// Shared definitions for the fetch response buffer: bus layout, reset level, pair packing.
`timescale 1ns/1ps
package if_resp_buffer_pkg;

    localparam int FETCH_BUS_W = 64;
    localparam int PC_HI       = 63;
    localparam int PC_LO       = 32;
    localparam int INST_HI     = 31;
    localparam int INST_LO     = 0;

    localparam logic RST_ACTIVE = 1'b1;

    function automatic logic [FETCH_BUS_W-1:0] pack_pair(input logic [31:0] pc,
                                                         input logic [31:0] inst);
        logic [FETCH_BUS_W-1:0] bus;
        bus                  = '0;
        bus[PC_HI:PC_LO]     = pc;
        bus[INST_HI:INST_LO] = inst;
        return bus;
    endfunction

endpackage

// File: rtl/if_resp_buffer_if.sv
// Fetch request/response/ID handshake bundle. Handshakes: a transfer happens in the cycle
// where valid (or fire) and ready are both high; valid never waits on ready.
`timescale 1ns/1ps
interface if_resp_buffer_if;
    import if_resp_buffer_pkg::*;

    logic [31:0]            req_pc;
    logic                   req_fire;
    logic                   req_ready;
    logic                   flush;
    logic                   resp_valid;
    logic [31:0]            resp_inst;
    logic                   out_valid;
    logic                   out_ready;
    logic [FETCH_BUS_W-1:0] out_bus;

    modport slave (
        input  req_pc, req_fire, flush, resp_valid, resp_inst, out_ready,
        output req_ready, out_valid, out_bus
    );

    modport master (
        output req_pc, req_fire, flush, resp_valid, resp_inst, out_ready,
        input  req_ready, out_valid, out_bus
    );

endinterface

// File: rtl/if_resp_buffer_fetch_fifo.sv
// Synchronous FIFO with clear; the head is kept in a register so it holds its last value when empty.
`timescale 1ns/1ps
module fetch_fifo
    import if_resp_buffer_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [WIDTH-1:0]         head_o,
    output logic                     nonempty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] ONE_CNT  = (PTR_W+1)'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             nonempty_q;
    logic             do_push, do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != FULL_CNT) || do_pop);

    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        head_d  = head_q;
        if (clear_i) begin
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + 1'b1;
            if (do_pop)  rd_d = rd_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + ONE_CNT;
                2'b01:   count_d = count_q - ONE_CNT;
                default: count_d = count_q;
            endcase
            // Head register follows the next entry; a push into an emptying FIFO lands directly.
            if (do_pop) begin
                if (count_q > ONE_CNT)  head_d = mem_q[rd_d];
                else if (do_push)       head_d = wdata_i;
            end else if (do_push && (count_q == '0)) begin
                head_d = wdata_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset == RST_ACTIVE) begin
            wr_q       <= '0;
            rd_q       <= '0;
            count_q    <= '0;
            head_q     <= '0;
            nonempty_q <= 1'b0;
        end else begin
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            count_q    <= count_d;
            head_q     <= head_d;
            nonempty_q <= (count_d != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!clear_i && do_push) mem_q[wr_q] <= wdata_i;
    end

    assign count_o    = count_q;
    assign head_o     = head_q;
    assign nonempty_o = nonempty_q;

endmodule

// File: rtl/if_resp_buffer.sv
// Pairs issued fetch PCs with returning instruction words and buffers {pc, inst} for ID.
// Optional same-cycle bypass when IF_RESP_BYPASS_EN is defined.
`timescale 1ns/1ps
module if_resp_buffer
    import if_resp_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset,
    if_resp_buffer_if.slave bus
);

    localparam int SUM_W = PTR_W + 3;

    logic [PTR_W:0]         pend_cnt, out_cnt;
    logic [PTR_W:0]         discard_q, discard_d, flush_sum;
    logic [31:0]            pend_head;
    logic [FETCH_BUS_W-1:0] out_head, resp_pair;
    logic                   pend_nonempty, out_nonempty;
    logic [SUM_W-1:0]       credit_used;
    logic                   req_ready, req_acc, resp_take, bypass;
    logic                   pend_push, out_push, out_pop;

    // Every issued request holds a credit until its pair leaves or its stale word is dropped.
    assign credit_used = SUM_W'(pend_cnt) + SUM_W'(out_cnt) + SUM_W'(discard_q);
    assign req_ready   = credit_used < SUM_W'(DEPTH);
    assign req_acc     = bus.req_fire && req_ready;

    assign resp_take = bus.resp_valid && !bus.flush && (discard_q == '0) && pend_nonempty;
    assign resp_pair = pack_pair(pend_head, bus.resp_inst);

`ifdef IF_RESP_BYPASS_EN
    assign bypass = resp_take && !out_nonempty && bus.out_ready;
`else
    assign bypass = 1'b0;
`endif

    assign pend_push = req_acc && !bus.flush;
    assign out_push  = resp_take && !bypass;
    assign out_pop   = out_nonempty && bus.out_ready;

    always_comb begin
        discard_d = discard_q;
        flush_sum = discard_q + pend_cnt + {{PTR_W{1'b0}}, req_acc};
        if (bus.flush) begin
            // A word arriving during the flush answers the oldest outstanding request.
            if (bus.resp_valid && (flush_sum != '0)) discard_d = flush_sum - 1'b1;
            else                                     discard_d = flush_sum;
        end else if (bus.resp_valid && (discard_q != '0)) begin
            discard_d = discard_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset == RST_ACTIVE) discard_q <= '0;
        else                     discard_q <= discard_d;
    end

    fetch_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_pend_fifo (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (bus.flush),
        .push_i     (pend_push),
        .wdata_i    (bus.req_pc),
        .pop_i      (resp_take),
        .count_o    (pend_cnt),
        .head_o     (pend_head),
        .nonempty_o (pend_nonempty)
    );

    fetch_fifo #(.WIDTH(FETCH_BUS_W), .DEPTH(DEPTH)) u_out_fifo (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (bus.flush),
        .push_i     (out_push),
        .wdata_i    (resp_pair),
        .pop_i      (out_pop),
        .count_o    (out_cnt),
        .head_o     (out_head),
        .nonempty_o (out_nonempty)
    );

    assign bus.req_ready = req_ready;
`ifdef IF_RESP_BYPASS_EN
    assign bus.out_valid = out_nonempty || bypass;
    assign bus.out_bus   = bypass ? resp_pair : out_head;
`else
    assign bus.out_valid = out_nonempty;
    assign bus.out_bus   = out_head;
`endif

endmodule

// File: tb/tb_if_resp_buffer.sv
// Directed bench for if_resp_buffer: in-order pairing, credit limit, flush discard, reset, bypass.
`timescale 1ns/1ps
module tb_if_resp_buffer;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    if_resp_buffer_if bus_if ();

    if_resp_buffer #(.DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus_if.req_pc     = '0;
        bus_if.req_fire   = 1'b0;
        bus_if.flush      = 1'b0;
        bus_if.resp_valid = 1'b0;
        bus_if.resp_inst  = '0;
    endtask

    task automatic fire(input logic [31:0] pc);
        idle_inputs();
        bus_if.req_pc   = pc;
        bus_if.req_fire = 1'b1;
        cycle();
        idle_inputs();
    endtask

    task automatic respond(input logic [31:0] inst);
        idle_inputs();
        bus_if.resp_valid = 1'b1;
        bus_if.resp_inst  = inst;
        cycle();
        idle_inputs();
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    logic [63:0] exp_q[$];

    task automatic check_pop(input string tag);
        logic [63:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_valid"}, 64'(bus_if.out_valid), 64'd1);
            check({tag, "_bus"}, bus_if.out_bus, e);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_checks = 0;
        n_errors = 0;
        idle_inputs();
        bus_if.out_ready = 1'b0;
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
        check("rst_valid", 64'(bus_if.out_valid), 64'd0);
        check("rst_bus",   bus_if.out_bus,        64'd0);
        check("rst_ready", 64'(bus_if.req_ready), 64'd1);

`ifdef IF_RESP_BYPASS_EN
        // Same-cycle bypass into an empty buffer
        bus_if.out_ready = 1'b1;
        fire(32'h1C00_0008);
        bus_if.resp_valid = 1'b1;
        bus_if.resp_inst  = 32'h0010_0000;
        #1;
        check("byp_valid", 64'(bus_if.out_valid), 64'd1);
        check("byp_bus",   bus_if.out_bus,        64'h1C00_0008_0010_0000);
        cycle();
        idle_inputs();
        #1;
        check("byp_after_valid", 64'(bus_if.out_valid), 64'd0);
        check("byp_after_ready", 64'(bus_if.req_ready), 64'd1);
`else
        // T1: two requests, two responses, one-cycle latency each
        bus_if.out_ready = 1'b1;
        fire(32'h1C00_0000);
        fire(32'h1C00_0004);
        exp_q.push_back(64'h1C00_0000_0280_0001);
        respond(32'h0280_0001);
        check_pop("t1_p0");
        exp_q.push_back(64'h1C00_0004_0280_0002);
        respond(32'h0280_0002);
        check_pop("t1_p1");
        cycle();
        check("t1_empty_valid", 64'(bus_if.out_valid), 64'd0);
        check("t1_hold_bus",    bus_if.out_bus,        64'h1C00_0004_0280_0002);

        // T2: credit limit with ID stalled, then in-order drain
        bus_if.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            fire(32'h1C00_0100 + 32'(4 * i));
            check($sformatf("t2_ready_%0d", i), 64'(bus_if.req_ready), (i == 3) ? 64'd0 : 64'd1);
        end
        for (int i = 0; i < 4; i++) begin
            respond(32'h0000_0100 + 32'(i));
            exp_q.push_back({32'h1C00_0100 + 32'(4 * i), 32'h0000_0100 + 32'(i)});
        end
        check("t2_full_ready", 64'(bus_if.req_ready), 64'd0);
        check_pop("t2_d0");
        bus_if.out_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            cycle();
            check_pop($sformatf("t2_d%0d", i));
        end
        cycle();
        check("t2_drained_valid", 64'(bus_if.out_valid), 64'd0);
        check("t2_drained_ready", 64'(bus_if.req_ready), 64'd1);

        // T3: flush with 3 outstanding plus a same-cycle request -> 4 stale words
        for (int i = 0; i < 3; i++) fire(32'h1C00_0200 + 32'(4 * i));
        bus_if.flush    = 1'b1;
        bus_if.req_fire = 1'b1;
        bus_if.req_pc   = 32'h1C00_020C;
        cycle();
        idle_inputs();
        check("t3_flush_valid", 64'(bus_if.out_valid), 64'd0);
        check("t3_flush_ready", 64'(bus_if.req_ready), 64'd0);
        for (int i = 0; i < 4; i++) begin
            respond(32'hDEAD_0000 + 32'(i));
            check($sformatf("t3_drop_%0d", i), 64'(bus_if.out_valid), 64'd0);
        end
        check("t3_credit_back", 64'(bus_if.req_ready), 64'd1);
        fire(32'h1C00_1000);
        exp_q.push_back(64'h1C00_1000_1234_5678);
        respond(32'h1234_5678);
        check_pop("t3_after");
        cycle();

        // T4: flush with one buffered pair and a response in the flush cycle
        bus_if.out_ready = 1'b0;
        fire(32'h1C00_2000);
        fire(32'h1C00_2010);
        exp_q.push_back(64'h1C00_2000_AAAA_0001);
        respond(32'hAAAA_0001);
        check_pop("t4_buffered");
        bus_if.flush      = 1'b1;
        bus_if.resp_valid = 1'b1;
        bus_if.resp_inst  = 32'hBBBB_0002;
        cycle();
        idle_inputs();
        check("t4_flush_valid", 64'(bus_if.out_valid), 64'd0);
        check("t4_flush_ready", 64'(bus_if.req_ready), 64'd1);
        bus_if.out_ready = 1'b1;
        fire(32'h1C00_2004);
        exp_q.push_back(64'h1C00_2004_0000_0002);
        respond(32'h0000_0002);
        check_pop("t4_no_discard");
        cycle();

        // T5: reset mid-stream with 2 buffered and 2 outstanding
        bus_if.out_ready = 1'b0;
        fire(32'h1C00_3000);
        fire(32'h1C00_3004);
        respond(32'h0000_0011);
        respond(32'h0000_0022);
        fire(32'h1C00_3008);
        fire(32'h1C00_300C);
        check("t5_pre_valid", 64'(bus_if.out_valid), 64'd1);
        check("t5_pre_ready", 64'(bus_if.req_ready), 64'd0);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("t5_rst_valid", 64'(bus_if.out_valid), 64'd0);
        check("t5_rst_ready", 64'(bus_if.req_ready), 64'd1);
        check("t5_rst_bus",   bus_if.out_bus,        64'd0);
        bus_if.out_ready = 1'b1;
        respond(32'h0000_0033);
        check("t5_late0", 64'(bus_if.out_valid), 64'd0);
        respond(32'h0000_0044);
        check("t5_late1", 64'(bus_if.out_valid), 64'd0);
        fire(32'h1C00_3010);
        exp_q.push_back(64'h1C00_3010_0000_0055);
        respond(32'h0000_0055);
        check_pop("t5_after");
        cycle();
        check("t5_end_valid", 64'(bus_if.out_valid), 64'd0);
`endif

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/if_resp_buffer.md
Name: if_resp_buffer

Overview:
- Response end of the fetch interface.
- The PC generator issues instruction addresses. This block records each accepted address, pairs it in order with the returning instruction word, and buffers {pc, inst} pairs for ID under a valid/ready handshake.
- On any redirect it drops in-flight responses for stale PCs, so the PC generator can retarget immediately.
- Sits between the PC generator / instruction memory port and the ID stage.

Parameters:
- DEPTH, 4, max outstanding requests plus buffered pairs; power of two, ≥2.
- PTR_W, $clog2(DEPTH), FIFO pointer width.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- req_pc  in  32  PC of the current fetch request.
- req_fire  in  1  request accepted by address translation this cycle.
- req_ready  out  1  credit available; upstream gates addr_trans_ready with it.
- flush  in  1  redirect this cycle (excp_flush | ertn_flush | is_branch).
- resp_valid  in  1  instruction word returned this cycle; in request order, ≥1 cycle after its req_fire.
- resp_inst  in  32  instruction word.
- out_valid  out  1  pair available to ID.
- out_ready  in  1  ID allowin.
- out_bus  out  64  {pc[63:32], inst[31:0]}.

Behaviour:
- State:
  - pending FIFO of PCs (DEPTH entries), pend_cnt.
  - out FIFO of 64-bit pairs (DEPTH entries), out_cnt.
  - discard_cnt, width PTR_W+1.
- Reset: both FIFOs empty, all counters 0, out_valid=0, out_bus=0, req_ready=1. Reset wins over every other input and clears the block mid-operation.
- req_ready = (pend_cnt + out_cnt + discard_cnt) < DEPTH, combinational from registers.
  - Guarantees neither FIFO overflows.
  - req_fire while req_ready=0 is a protocol error; the RTL ignores it.
- req_fire (no flush): push req_pc into the pending FIFO.
- resp_valid (no flush):
  - If discard_cnt>0: decrement discard_cnt; drop the word.
  - Otherwise: pop the pending head and push {pc, resp_inst} into the out FIFO.
  - resp_valid with pend_cnt=0 and discard_cnt=0: ignored.
- Output:
  - out_valid = (out_cnt != 0).
  - out_bus = out FIFO head, registered. When empty, out_bus holds the last value; 0 after reset.
  - Pop on out_valid & out_ready.
  - Push and pop in the same cycle are both performed.
- Latency: response at cycle t gives out_valid at t+1. Full throughput is one pair per cycle.
- flush:
  - Out FIFO and pending FIFO cleared.
  - discard_cnt_next = discard_cnt + pend_cnt + req_fire − resp_valid.
  - A req_fire in the flush cycle is treated as stale and is not pushed.
  - A resp_valid in the flush cycle is always dropped.
  - An out_valid & out_ready pop in the flush cycle counts as consumed by ID; ID is responsible for squashing it.
  - out_valid=0 from the next cycle.
- Back-to-back flushes accumulate correctly in discard_cnt. discard_cnt never exceeds DEPTH.

Optional Feature:
- IF_RESP_BYPASS_EN defined:
  - When the out FIFO is empty, the response is not discarded, and out_ready=1, the pair {pc, resp_inst} drives out_bus with out_valid=1 in the same cycle (combinational bypass).
  - Nothing is pushed in that case.
  - Latency is 0 cycles.
  - Flush still suppresses the bypass (out_valid=0 when flush=1).
- Not defined: always the registered path, 1-cycle latency. out_valid/out_bus are pure register outputs.

Decomposition:
- Shared package (defines):
  - FETCH_BUS_W=64.
  - Bus field positions PC_HI=63, PC_LO=32, INST_HI=31, INST_LO=0.
  - The reset-active level constant already used by the codebase.
- One natural sub-module: fetch_fifo.
  - Parameterised width/depth synchronous FIFO with push, pop, clear, count, head.
  - Instantiated twice: 32-bit pending, 64-bit out.

Test Plan:
- Reset, then req_fire with req_pc=0x1C000000,0x1C000004; resp_valid with 0x02800001 then 0x02800002 one cycle later; out_ready=1 → out_bus=0x1C000000_02800001 then 0x1C000004_02800002, each one cycle after its response.
- DEPTH=4, out_ready=0, 4 requests and 4 responses → req_ready=0 after the 4th req_fire; out_cnt=4; releasing out_ready drains in order and req_ready returns to 1.
- 3 outstanding requests, flush with simultaneous req_fire and no resp → discard_cnt=4; the next 4 responses produce no out_valid; the request at 0x1C001000 after that appears with its inst.
- Flush in the same cycle as resp_valid with pend_cnt=1 → response dropped, discard_cnt stays 0, out_valid=0 next cycle.
- Assert reset mid-stream with 2 outstanding and 2 buffered → next cycle out_valid=0, req_ready=1, out_bus=0; late responses ignored.
- With IF_RESP_BYPASS_EN, empty buffer, out_ready=1, resp 0x00100000 for PC 0x1C000008 → out_valid=1 and out_bus=0x1C000008_00100000 in the same cycle.
